// File: rtl/if_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: NOP encoding, state encoding, width default.
package if_fetch_unit_pkg;

  localparam int unsigned XLEN_DEFAULT = 32;
  localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_HOLD = 2'd2,
    ST_DROP = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/if_skid_buf.sv
// One-entry skid buffer parking an instruction that returned while the pipeline was stalled.
module if_skid_buf
  import if_fetch_unit_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            load_i,
  input  logic            unload_i,
  input  logic            clear_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] instr_i,
  output logic            valid_o,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] instr_o
);

  localparam logic [XLEN-1:0] NOP_X = XLEN'(NOP_INSTR);

  logic            valid_d, valid_q;
  logic [XLEN-1:0] pc_d, pc_q;
  logic [XLEN-1:0] instr_d, instr_q;

  // clear wins over load so a redirect can never leave a stale entry behind
  always_comb begin
    valid_d = valid_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    if (clear_i || unload_i) begin
      valid_d = 1'b0;
    end else if (load_i) begin
      valid_d = 1'b1;
      pc_d    = pc_i;
      instr_d = instr_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      instr_q <= NOP_X;
    end else begin
      valid_q <= valid_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  assign valid_o = valid_q;
  assign pc_o    = pc_q;
  assign instr_o = instr_q;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: PC sequencing, imem handshake, IF/ID register, stall skid and flush drop.
// state | meaning
// IDLE  | post-reset cycle, no request
// REQ   | request at pc outstanding
// HOLD  | acked instruction parked in skid buffer while stalled
// DROP  | request from before a flush still in flight; its data is discarded
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter int              XLEN     = XLEN_DEFAULT,
  parameter logic [XLEN-1:0] PC_RESET = '0
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            stall_i,
  input  logic            flush_i,
  input  logic [XLEN-1:0] target_i,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_ack_i,
  input  logic [XLEN-1:0] imem_rdata_i,
  output logic [XLEN-1:0] ifid_pc_o,
  output logic [XLEN-1:0] ifid_instr_o,
  output logic            ifid_valid_o,
  output logic            fetch_busy_o
);

  localparam logic [XLEN-1:0] NOP_X = XLEN'(NOP_INSTR);
  localparam logic [XLEN-1:0] PC_INC = XLEN'(4);

  fetch_state_e    state_d, state_q;
  logic [XLEN-1:0] pc_d, pc_q;
  logic [XLEN-1:0] drop_addr_d, drop_addr_q;
  logic [XLEN-1:0] ifid_pc_d, ifid_pc_q;
  logic [XLEN-1:0] ifid_instr_d, ifid_instr_q;
  logic            ifid_valid_d, ifid_valid_q;

  logic            skid_load, skid_unload, skid_clear, skid_valid;
  logic [XLEN-1:0] skid_pc, skid_instr;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    drop_addr_d  = drop_addr_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_instr_d = ifid_instr_q;
    ifid_valid_d = ifid_valid_q;
    skid_load    = 1'b0;
    skid_unload  = 1'b0;
    skid_clear   = 1'b0;
    if (flush_i) begin
      pc_d         = target_i;
      ifid_valid_d = 1'b0;
      ifid_instr_d = NOP_X;
      skid_clear   = 1'b1;
      state_d      = ST_REQ;
      // an un-acked request cannot be withdrawn; wait it out with its original address
      if ((state_q == ST_REQ || state_q == ST_DROP) && !imem_ack_i) begin
        state_d = ST_DROP;
      end
      if (state_q == ST_REQ) begin
        drop_addr_d = pc_q;
      end
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_REQ;
        ST_REQ: begin
          if (imem_ack_i) begin
            if (stall_i) begin
              skid_load = 1'b1;
              state_d   = ST_HOLD;
            end else begin
              ifid_pc_d    = pc_q;
              ifid_instr_d = imem_rdata_i;
              ifid_valid_d = 1'b1;
              pc_d         = pc_q + PC_INC;
            end
          end else if (!stall_i) begin
            ifid_valid_d = 1'b0;
            ifid_instr_d = NOP_X;
          end
        end
        ST_HOLD: begin
          if (!stall_i) begin
            ifid_pc_d    = skid_pc;
            ifid_instr_d = skid_instr;
            ifid_valid_d = skid_valid;
            skid_unload  = 1'b1;
            pc_d         = pc_q + PC_INC;
            state_d      = ST_REQ;
          end
        end
        ST_DROP: begin
          ifid_valid_d = 1'b0;
          ifid_instr_d = NOP_X;
          if (imem_ack_i) begin
            state_d = ST_REQ;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      pc_q         <= PC_RESET;
      drop_addr_q  <= '0;
      ifid_pc_q    <= '0;
      ifid_instr_q <= NOP_X;
      ifid_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      drop_addr_q  <= drop_addr_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_valid_q <= ifid_valid_d;
    end
  end

  if_skid_buf #(.XLEN(XLEN)) u_skid (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .load_i   (skid_load),
    .unload_i (skid_unload),
    .clear_i  (skid_clear),
    .pc_i     (pc_q),
    .instr_i  (imem_rdata_i),
    .valid_o  (skid_valid),
    .pc_o     (skid_pc),
    .instr_o  (skid_instr)
  );

  // request is masked while reset is asserted, whatever state the flops still hold
  assign imem_req_o   = (state_q == ST_REQ || state_q == ST_DROP) && !rst_i;
  assign imem_addr_o  = (state_q == ST_DROP) ? drop_addr_q : pc_q;
  assign fetch_busy_o = imem_req_o && !imem_ack_i;
  assign ifid_pc_o    = ifid_pc_q;
  assign ifid_instr_o = ifid_instr_q;
  assign ifid_valid_o = ifid_valid_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit with an in-order scoreboard of instructions expected in IF/ID.
module tb_if_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] KEY = 32'h0000_00A5;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        stall_i;
  logic        flush_i;
  logic [31:0] target_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ack_i;
  logic [31:0] imem_rdata_i;
  logic [31:0] ifid_pc_o;
  logic [31:0] ifid_instr_o;
  logic        ifid_valid_o;
  logic        fetch_busy_o;

  int n_checks = 0;
  int n_errors = 0;

  logic [63:0] sb_q[$];
  logic        prev_valid = 1'b0;
  logic [31:0] prev_pc = '0;

  always #5 clk_i = ~clk_i;

  if_fetch_unit dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .stall_i      (stall_i),
    .flush_i      (flush_i),
    .target_i     (target_i),
    .imem_req_o   (imem_req_o),
    .imem_addr_o  (imem_addr_o),
    .imem_ack_i   (imem_ack_i),
    .imem_rdata_i (imem_rdata_i),
    .ifid_pc_o    (ifid_pc_o),
    .ifid_instr_o (ifid_instr_o),
    .ifid_valid_o (ifid_valid_o),
    .fetch_busy_o (fetch_busy_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // memory returns addr^KEY so every instruction is tied to the address it was fetched from
  task automatic drive(input logic a, input logic s, input logic f, input logic [31:0] t);
    imem_ack_i   = a;
    stall_i      = s;
    flush_i      = f;
    target_i     = t;
    imem_rdata_i = imem_addr_o ^ KEY;
    #1;
  endtask

  task automatic push(input logic [31:0] pc);
    sb_q.push_back({pc, pc ^ KEY});
  endtask

  // each new valid IF/ID entry must be the next expected instruction
  always @(negedge clk_i) begin
    logic [63:0] exp;
    if (ifid_valid_o && (!prev_valid || ifid_pc_o != prev_pc)) begin
      exp = (sb_q.size() > 0) ? sb_q.pop_front() : 64'hDEAD_DEAD_DEAD_DEAD;
      chk("sb_pc", ifid_pc_o, exp[63:32]);
      chk("sb_instr", ifid_instr_o, exp[31:0]);
    end
    prev_valid <= ifid_valid_o;
    prev_pc    <= ifid_pc_o;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, checks %0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i = 1'b1;
    imem_ack_i = 1'b0; stall_i = 1'b0; flush_i = 1'b0; target_i = '0; imem_rdata_i = '0;
    tick(); tick();
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    chk("rst_req", {31'd0, imem_req_o}, 32'd0);
    chk("rst_busy", {31'd0, fetch_busy_o}, 32'd0);
    chk("rst_valid", {31'd0, ifid_valid_o}, 32'd0);
    chk("rst_instr", ifid_instr_o, NOP);
    chk("rst_pc", ifid_pc_o, 32'd0);

    // sequential fetch, ack every cycle; ack in IDLE is ignored
    rst_i = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    chk("idle_req", {31'd0, imem_req_o}, 32'd0);
    chk("idle_busy", {31'd0, fetch_busy_o}, 32'd0);
    tick();
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 1'b0, 1'b0, 32'h0);
      chk("seq_req", {31'd0, imem_req_o}, 32'd1);
      chk("seq_addr", imem_addr_o, 32'(4 * k));
      push(32'(4 * k));
      tick();
      chk("seq_valid", {31'd0, ifid_valid_o}, 32'd1);
    end

    // delayed ack at 0x10
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 1'b0, 32'h0);
      chk("dly_addr", imem_addr_o, 32'h10);
      chk("dly_busy", {31'd0, fetch_busy_o}, 32'd1);
      tick();
      chk("dly_bub_valid", {31'd0, ifid_valid_o}, 32'd0);
      chk("dly_bub_instr", ifid_instr_o, NOP);
    end
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    chk("dly_addr_ack", imem_addr_o, 32'h10);
    chk("dly_busy_ack", {31'd0, fetch_busy_o}, 32'd0);
    push(32'h10);
    tick();

    // stall two cycles, ack on the first
    drive(1'b1, 1'b1, 1'b0, 32'h0);
    chk("stl_addr", imem_addr_o, 32'h14);
    push(32'h14);
    tick();
    chk("stl_ifid_pc", ifid_pc_o, 32'h10);
    chk("stl_skid", {31'd0, dut.u_skid.valid_o}, 32'd1);
    drive(1'b1, 1'b1, 1'b0, 32'h0);
    chk("hold_req", {31'd0, imem_req_o}, 32'd0);
    chk("hold_busy", {31'd0, fetch_busy_o}, 32'd0);
    tick();
    chk("hold_ifid_pc", ifid_pc_o, 32'h10);
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    chk("unstl_ifid_pc", ifid_pc_o, 32'h14);
    chk("unstl_instr", ifid_instr_o, 32'h14 ^ KEY);
    for (int k = 0; k < 2; k++) begin
      drive(1'b1, 1'b0, 1'b0, 32'h0);
      chk("seq2_addr", imem_addr_o, 32'(32'h18 + 4 * k));
      push(32'(32'h18 + 4 * k));
      tick();
    end

    // flush to 0x100 while 0x20 outstanding, ack two cycles later
    drive(1'b0, 1'b0, 1'b1, 32'h100);
    chk("fl_addr", imem_addr_o, 32'h20);
    tick();
    chk("fl_valid", {31'd0, ifid_valid_o}, 32'd0);
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    chk("drop_req", {31'd0, imem_req_o}, 32'd1);
    chk("drop_addr", imem_addr_o, 32'h20);
    chk("drop_busy", {31'd0, fetch_busy_o}, 32'd1);
    tick();
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    chk("drop_addr_ack", imem_addr_o, 32'h20);
    tick();
    chk("drop_valid", {31'd0, ifid_valid_o}, 32'd0);
    for (int k = 0; k < 2; k++) begin
      drive(1'b1, 1'b0, 1'b0, 32'h0);
      chk("redir_addr", imem_addr_o, 32'(32'h100 + 4 * k));
      push(32'(32'h100 + 4 * k));
      tick();
    end

    // flush, stall and ack together
    drive(1'b1, 1'b1, 1'b1, 32'h40);
    chk("fsa_addr", imem_addr_o, 32'h108);
    tick();
    chk("fsa_valid", {31'd0, ifid_valid_o}, 32'd0);
    chk("fsa_instr", ifid_instr_o, NOP);
    chk("fsa_skid", {31'd0, dut.u_skid.valid_o}, 32'd0);
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    chk("fsa_req", {31'd0, imem_req_o}, 32'd1);
    chk("fsa_next_addr", imem_addr_o, 32'h40);
    push(32'h40);
    tick();

    // double flush in DROP, stall does not hold DROP, then reset during DROP
    drive(1'b0, 1'b0, 1'b1, 32'h300);
    chk("dd_addr0", imem_addr_o, 32'h44);
    tick();
    drive(1'b0, 1'b0, 1'b1, 32'h400);
    chk("dd_addr1", imem_addr_o, 32'h44);
    chk("dd_busy", {31'd0, fetch_busy_o}, 32'd1);
    tick();
    drive(1'b1, 1'b1, 1'b0, 32'h0);
    chk("dd_addr2", imem_addr_o, 32'h44);
    tick();
    drive(1'b0, 1'b0, 1'b1, 32'h500);
    chk("dd_new_addr", imem_addr_o, 32'h400);
    chk("dd_valid", {31'd0, ifid_valid_o}, 32'd0);
    tick();
    rst_i = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    chk("rd_req_in_rst", {31'd0, imem_req_o}, 32'd0);
    tick();
    rst_i = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    chk("rd_req", {31'd0, imem_req_o}, 32'd0);
    chk("rd_busy", {31'd0, fetch_busy_o}, 32'd0);
    chk("rd_valid", {31'd0, ifid_valid_o}, 32'd0);
    chk("rd_instr", ifid_instr_o, NOP);
    chk("rd_ifid_pc", ifid_pc_o, 32'd0);
    tick();
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    chk("rd_addr", imem_addr_o, 32'h0);
    push(32'h0);
    tick();

    drive(1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    tick();
    chk("sb_drain", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
